mig_cp_addr_remap: RTL and testbench

- Request-side consumer of the MIG control-plane partition table.
- Accepts DSID-tagged memory requests from the AXI front end and drives the table's tag-lookup port with the request DSID.
- Uses the returned {length, base} pair to relocate the address into the DSID's partition and bounds-check the burst.
- Forwards legal requests to the MIG and diverts misses and out-of-bound requests to an error channel, with one-cycle registered latency.

---
 rtl/mig_cp_pkg.sv | 23 ++
 rtl/mig_cp_sat_counter.sv | 35 +++
 rtl/mig_cp_addr_remap.sv | 156 +++++++++++++++
 tb/tb_mig_cp_addr_remap.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_cp_pkg.sv
// Shared definitions for the MIG control-plane request path: error codes,
// partition-table entry layout and small elaboration helpers.
package mig_cp_pkg;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MISS = 2'b01;
  localparam logic [1:0] ERR_OOB  = 2'b10;

  // A table entry is packed as {len, base}, with base in the low bits.
  localparam int unsigned TE_BASE_LSB = 0;

  function automatic int unsigned f_len_lsb(input int unsigned base_width);
    return base_width;
  endfunction

  function automatic int unsigned f_ceil_log2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/mig_cp_sat_counter.sv
// Saturating event counter with a synchronous clear that wins over increment.
module mig_cp_sat_counter #(
  parameter int unsigned C_WIDTH = 32
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               inc,
  input  logic               clr,
  output logic [C_WIDTH-1:0] q
);

  logic [C_WIDTH-1:0] cnt_q;
  logic [C_WIDTH-1:0] cnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/mig_cp_addr_remap.sv
// Relocates DSID-tagged requests into their partition using the control-plane
// table, bounds-checks the burst and routes it to the MIG or the error channel.
module mig_cp_addr_remap
  import mig_cp_pkg::*;
#(
  parameter int unsigned C_TAG_WIDTH      = 16,
  parameter int unsigned C_ADDR_WIDTH     = 32,
  parameter int unsigned C_BASE_WIDTH     = 32,
  parameter int unsigned C_LENGTH_WIDTH   = 32,
  parameter int unsigned C_ID_WIDTH       = 4,
  parameter int unsigned C_BEAT_BYTES_LOG = 4,
  parameter int unsigned C_CNT_WIDTH      = 32
) (
  input  logic                                   aclk,
  input  logic                                   areset,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic [C_ADDR_WIDTH-1:0]                s_addr,
  input  logic [C_TAG_WIDTH-1:0]                 s_dsid,
  input  logic [7:0]                             s_len,
  input  logic [C_ID_WIDTH-1:0]                  s_id,
  output logic [C_TAG_WIDTH-1:0]                 tag_a,
  input  logic [C_LENGTH_WIDTH+C_BASE_WIDTH-1:0] do_a,
  input  logic                                   tag_match_a,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [C_ADDR_WIDTH-1:0]                m_addr,
  output logic [7:0]                             m_len,
  output logic [C_ID_WIDTH-1:0]                  m_id,
  output logic                                   err_valid,
  input  logic                                   err_ready,
  output logic [C_ID_WIDTH-1:0]                  err_id,
  output logic [1:0]                             err_code,
  input  logic                                   cnt_clear,
  output logic [C_CNT_WIDTH-1:0]                 cnt_ok,
  output logic [C_CNT_WIDTH-1:0]                 cnt_err
);

  localparam int unsigned AW1  = C_ADDR_WIDTH + 1;
  localparam int unsigned CMPW =
    ((C_ADDR_WIDTH > C_LENGTH_WIDTH) ? C_ADDR_WIDTH : C_LENGTH_WIDTH) + 1;

  logic                      slot_valid_q, slot_valid_d;
  logic                      slot_err_q,   slot_err_d;
  logic [1:0]                slot_code_q,  slot_code_d;
  logic [C_ADDR_WIDTH-1:0]   slot_addr_q,  slot_addr_d;
  logic [7:0]                slot_len_q,   slot_len_d;
  logic [C_ID_WIDTH-1:0]     slot_id_q,    slot_id_d;

  logic [C_BASE_WIDTH-1:0]   base;
  logic [C_LENGTH_WIDTH-1:0] plen;
  logic [AW1-1:0]            burst_bytes;
  logic [AW1-1:0]            end_addr;
  logic                      oob;
  logic                      accept;
  logic                      fire_out;
  logic                      fire_ok;
  logic                      fire_err;
  logic                      cls_err;
  logic [1:0]                cls_code;
  logic [C_ADDR_WIDTH-1:0]   cls_addr;

  assign tag_a = s_dsid;
  assign base  = do_a[TE_BASE_LSB +: C_BASE_WIDTH];
  assign plen  = do_a[f_len_lsb(C_BASE_WIDTH) +: C_LENGTH_WIDTH];

  assign m_valid   = slot_valid_q & ~slot_err_q;
  assign err_valid = slot_valid_q &  slot_err_q;
  assign fire_ok   = m_valid & m_ready;
  assign fire_err  = err_valid & err_ready;
  assign fire_out  = fire_ok | fire_err;
  assign s_ready   = ~slot_valid_q | fire_out;
  assign accept    = s_valid & s_ready;

  // The burst end is kept one bit wider than the address so it never wraps.
  assign burst_bytes = AW1'({1'b0, s_len} + 9'd1) << C_BEAT_BYTES_LOG;
  assign end_addr    = AW1'(s_addr) + burst_bytes;
  assign oob         = (plen == '0) || (CMPW'(end_addr) > CMPW'(plen));

  always_comb begin
    cls_err  = 1'b0;
    cls_code = ERR_NONE;
    cls_addr = '0;
    if (!tag_match_a) begin
      cls_err  = 1'b1;
      cls_code = ERR_MISS;
    end else if (oob) begin
      cls_err  = 1'b1;
      cls_code = ERR_OOB;
    end else begin
      cls_addr = base + s_addr;
    end
  end

  // A held slot only changes once it fires, so later table writes cannot
  // disturb it; accept and fire in the same cycle reload with no bubble.
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_err_d   = slot_err_q;
    slot_code_d  = slot_code_q;
    slot_addr_d  = slot_addr_q;
    slot_len_d   = slot_len_q;
    slot_id_d    = slot_id_q;
    if (accept) begin
      slot_valid_d = 1'b1;
      slot_err_d   = cls_err;
      slot_code_d  = cls_code;
      slot_addr_d  = cls_addr;
      slot_len_d   = s_len;
      slot_id_d    = s_id;
    end else if (fire_out) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      slot_valid_q <= 1'b0;
      slot_err_q   <= 1'b0;
      slot_code_q  <= ERR_NONE;
      slot_addr_q  <= '0;
      slot_len_q   <= '0;
      slot_id_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_err_q   <= slot_err_d;
      slot_code_q  <= slot_code_d;
      slot_addr_q  <= slot_addr_d;
      slot_len_q   <= slot_len_d;
      slot_id_q    <= slot_id_d;
    end
  end

  assign m_addr   = slot_addr_q;
  assign m_len    = slot_len_q;
  assign m_id     = slot_id_q;
  assign err_id   = slot_id_q;
  assign err_code = slot_code_q;

  mig_cp_sat_counter #(.C_WIDTH(C_CNT_WIDTH)) u_cnt_ok (
    .aclk   (aclk),
    .areset (areset),
    .inc    (fire_ok),
    .clr    (cnt_clear),
    .q      (cnt_ok)
  );

  mig_cp_sat_counter #(.C_WIDTH(C_CNT_WIDTH)) u_cnt_err (
    .aclk   (aclk),
    .areset (areset),
    .inc    (fire_err),
    .clr    (cnt_clear),
    .q      (cnt_err)
  );

endmodule

// File: tb/tb_mig_cp_addr_remap.sv
// Directed bench for mig_cp_addr_remap; a second instance with 2-bit counters
// shares the stimulus so counter saturation becomes observable.
module tb_mig_cp_addr_remap;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_addr;
  logic [15:0] s_dsid;
  logic [7:0]  s_len;
  logic [3:0]  s_id;
  logic [15:0] tag_a;
  logic [63:0] do_a;
  logic        tag_match_a;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [3:0]  m_id;
  logic        err_valid;
  logic        err_ready;
  logic [3:0]  err_id;
  logic [1:0]  err_code;
  logic        cnt_clear;
  logic [31:0] cnt_ok;
  logic [31:0] cnt_err;

  logic        s_ready_s, m_valid_s, err_valid_s;
  logic [15:0] tag_a_s;
  logic [31:0] m_addr_s;
  logic [7:0]  m_len_s;
  logic [3:0]  m_id_s, err_id_s;
  logic [1:0]  err_code_s;
  logic [1:0]  cnt_ok_s, cnt_err_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;

  mig_cp_addr_remap dut (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_dsid(s_dsid),
    .s_len(s_len), .s_id(s_id),
    .tag_a(tag_a), .do_a(do_a), .tag_match_a(tag_match_a),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_len(m_len), .m_id(m_id),
    .err_valid(err_valid), .err_ready(err_ready), .err_id(err_id), .err_code(err_code),
    .cnt_clear(cnt_clear), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  mig_cp_addr_remap #(.C_CNT_WIDTH(2)) dut_small (
    .aclk(aclk), .areset(areset),
    .s_valid(s_valid), .s_ready(s_ready_s), .s_addr(s_addr), .s_dsid(s_dsid),
    .s_len(s_len), .s_id(s_id),
    .tag_a(tag_a_s), .do_a(do_a), .tag_match_a(tag_match_a),
    .m_valid(m_valid_s), .m_ready(m_ready), .m_addr(m_addr_s), .m_len(m_len_s), .m_id(m_id_s),
    .err_valid(err_valid_s), .err_ready(err_ready), .err_id(err_id_s), .err_code(err_code_s),
    .cnt_clear(cnt_clear), .cnt_ok(cnt_ok_s), .cnt_err(cnt_err_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge, away from the active edge.
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic [15:0] dsid,
                           input logic [7:0] len, input logic [3:0] id,
                           input logic hit, input logic [31:0] base,
                           input logic [31:0] plen);
    s_valid     = 1'b1;
    s_addr      = addr;
    s_dsid      = dsid;
    s_len       = len;
    s_id        = id;
    tag_match_a = hit;
    do_a        = {plen, base};
    #1;
  endtask

  task automatic idle_req();
    s_valid     = 1'b0;
    tag_match_a = 1'b0;
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1;
    s_valid = 1'b0; s_addr = '0; s_dsid = '0; s_len = '0; s_id = '0;
    do_a = '0; tag_match_a = 1'b0;
    m_ready = 1'b1; err_ready = 1'b1; cnt_clear = 1'b0;
    step();
    check("rst_m_valid", m_valid, 0);
    check("rst_err_valid", err_valid, 0);
    step();
    areset = 1'b0;
    #1;
    check("rst_s_ready", s_ready, 1);
    check("rst_cnt_ok", cnt_ok, 0);
    check("rst_cnt_err", cnt_err, 0);

    // Hit in range
    drive_req(32'h100, 16'h0007, 8'd3, 4'd5, 1'b1, 32'h4000_0000, 32'h0010_0000);
    check("hit_tag_a", tag_a, 16'h0007);
    check("hit_s_ready", s_ready, 1);
    step(); idle_req();
    check("hit_m_valid", m_valid, 1);
    check("hit_err_valid", err_valid, 0);
    check("hit_m_addr", m_addr, 32'h4000_0100);
    check("hit_m_len", m_len, 3);
    check("hit_m_id", m_id, 5);
    step();
    check("hit_cnt_ok", cnt_ok, 1);
    check("hit_done", m_valid, 0);

    // Tag miss
    drive_req(32'h0, 16'h0009, 8'd0, 4'd2, 1'b0, 32'h4000_0000, 32'h0010_0000);
    step(); idle_req();
    check("miss_err_valid", err_valid, 1);
    check("miss_m_valid", m_valid, 0);
    check("miss_err_code", err_code, 2'b01);
    check("miss_err_id", err_id, 2);
    step();
    check("miss_cnt_err", cnt_err, 1);

    // Bounds edge: end exactly at the partition length is legal
    drive_req(32'hFF0, 16'h0003, 8'd0, 4'd6, 1'b1, 32'h1000_0000, 32'h1000);
    step(); idle_req();
    check("edge_ok_m_valid", m_valid, 1);
    check("edge_ok_m_addr", m_addr, 32'h1000_0FF0);
    step();
    drive_req(32'hFF1, 16'h0003, 8'd0, 4'd7, 1'b1, 32'h1000_0000, 32'h1000);
    step(); idle_req();
    check("edge_oob_err_valid", err_valid, 1);
    check("edge_oob_code", err_code, 2'b10);
    check("edge_oob_id", err_id, 7);
    step();
    drive_req(32'h0, 16'h0003, 8'd0, 4'd8, 1'b1, 32'h1000_0000, 32'h0);
    step(); idle_req();
    check("zero_len_code", err_code, 2'b10);
    check("zero_len_m_valid", m_valid, 0);
    step();
    // Largest burst: 256 beats * 16 B = 0x1000 fills the partition exactly
    drive_req(32'h0, 16'h0003, 8'd255, 4'd9, 1'b1, 32'h2000_0000, 32'h1000);
    step(); idle_req();
    check("maxburst_m_valid", m_valid, 1);
    check("maxburst_m_addr", m_addr, 32'h2000_0000);
    step();
    drive_req(32'h10, 16'h0003, 8'd255, 4'd10, 1'b1, 32'h2000_0000, 32'h1000);
    step(); idle_req();
    check("maxburst_oob_code", err_code, 2'b10);
    step();
    check("bounds_cnt_ok", cnt_ok, 3);
    check("bounds_cnt_err", cnt_err, 4);

    // Backpressure with a table rewrite while the first request is held
    m_ready = 1'b0;
    drive_req(32'h20, 16'h0011, 8'd1, 4'd3, 1'b1, 32'h8000_0000, 32'h1000);
    step();
    drive_req(32'h40, 16'h0012, 8'd2, 4'd4, 1'b1, 32'h9000_0000, 32'h1000);
    check("bp_s_ready_blocked", s_ready, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_m_valid", m_valid, 1);
      check("bp_hold_m_addr", m_addr, 32'h8000_0020);
      check("bp_hold_m_id", m_id, 3);
      check("bp_hold_s_ready", s_ready, 0);
    end
    m_ready = 1'b1;
    #1;
    check("bp_release_s_ready", s_ready, 1);
    step(); idle_req();
    check("bp_second_m_valid", m_valid, 1);
    check("bp_second_m_addr", m_addr, 32'h9000_0040);
    check("bp_second_m_id", m_id, 4);
    check("bp_second_m_len", m_len, 2);
    step();
    check("bp_drained", m_valid, 0);
    check("bp_cnt_ok", cnt_ok, 5);

    // Clear, then stream alternating hit/miss at full rate
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check("clear_cnt_ok", cnt_ok, 0);
    check("clear_cnt_err", cnt_err, 0);
    for (int i = 0; i < 100; i++) begin
      drive_req(32'h0, 16'(i), 8'd0, 4'(i), (i % 2 == 0), 32'h100, 32'h1000);
      check("stream_s_ready", s_ready, 1);
      step();
    end
    idle_req();
    step();
    check("stream_cnt_ok", cnt_ok, 50);
    check("stream_cnt_err", cnt_err, 50);
    check("sat_cnt_ok", cnt_ok_s, 2'b11);
    check("sat_cnt_err", cnt_err_s, 2'b11);
    drive_req(32'h0, 16'h0001, 8'd0, 4'd1, 1'b1, 32'h100, 32'h1000);
    step(); idle_req();
    step();
    check("sat_more_cnt_ok", cnt_ok, 51);
    check("sat_hold_cnt_ok", cnt_ok_s, 2'b11);

    // Clear wins over a completion in the same cycle
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    drive_req(32'h0, 16'h0001, 8'd0, 4'd1, 1'b1, 32'h100, 32'h1000);
    step(); idle_req();
    check("clr_pending_m_valid", m_valid, 1);
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    check("clr_on_fire_cnt_ok", cnt_ok, 0);
    check("clr_on_fire_m_valid", m_valid, 0);

    // Reset while a request is held
    m_ready = 1'b0;
    drive_req(32'h0, 16'h0001, 8'd0, 4'd1, 1'b1, 32'h100, 32'h1000);
    step(); idle_req();
    check("rst_mid_pending", m_valid, 1);
    areset = 1'b1;
    #1;
    check("rst_mid_m_valid", m_valid, 0);
    step();
    areset = 1'b0;
    #1;
    check("rst_mid_s_ready", s_ready, 1);
    m_ready = 1'b1;
    step();
    check("rst_mid_dropped", m_valid, 0);
    check("rst_mid_cnt_ok", cnt_ok, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
